// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of one synchronous RAM port.
// Supports bounded locked bursts and routes one-cycle-latency read data back.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  lock0,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e     state_q, state_d;
    logic       prio_q, prio_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic [8:0] burst_next;
    logic       lock_sel;
    logic       own0, own1;

    // Grant decision and RAM port mux
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;

        own0 = (state_q == StOwn0) && req0;
        own1 = (state_q == StOwn1) && req1;

        if (own0) begin
            gnt0 = 1'b1;
        end else if (own1) begin
            gnt1 = 1'b1;
        end else if (req0 && (!req1 || !prio_q)) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end

        if (gnt0) begin
            mem_addr  = addr0;
            mem_we    = we0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_we    = we1;
            mem_wdata = wdata1;
        end
    end

    // Next-state: pointer, burst lock and read-valid tracking
    always_comb begin
        state_d     = StIdle;
        burst_cnt_d = '0;
        prio_d      = prio_q;
        burst_next  = {1'b0, burst_cnt_q} + 9'd1;
        lock_sel    = gnt0 ? lock0 : lock1;
        rvalid0_d   = gnt0 && !we0;
        rvalid1_d   = gnt1 && !we1;

        if (gnt0 || gnt1) begin
            // Favour the other requester at the next contention.
            prio_d = gnt0;
            if (lock_sel && (32'(burst_next) < MAX_BURST)) begin
                state_d     = gnt0 ? StOwn0 : StOwn1;
                burst_cnt_d = burst_next[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            burst_cnt_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous RAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [15:0] ram [0:65535];

    int checks = 0;
    int errors = 0;

    logic        pg;
    logic [15:0] pd;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .MAX_BURST (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .lock0    (lock0),
        .lock1    (lock1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Read-before-write synchronous RAM
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic l);
        req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
    endtask

    task automatic set1(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic l);
        req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ram[16'h0010] = 16'h1234;
        ram[16'h0020] = 16'h5678;
        ram[16'h0030] = 16'h1111;
        ram[16'h0040] = 16'h2222;
        reset = 1'b1;
        set0(0, 0, 16'h0, 16'h0, 0);
        set1(0, 0, 16'h0, 16'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        // Idle inputs present but not requesting must not reach the RAM.
        set0(0, 1, 16'hAAAA, 16'h5555, 0);
        #1;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        chk16("rst_mem_wdata", mem_wdata, 16'h0000);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);

        // Single read by requester 0
        tick();
        set0(1, 0, 16'h0010, 16'h0, 0);
        #1;
        chk1("t1_gnt0", gnt0, 1'b1);
        chk1("t1_gnt1", gnt1, 1'b0);
        chk16("t1_mem_addr", mem_addr, 16'h0010);
        chk1("t1_mem_we", mem_we, 1'b0);

        tick();
        set0(0, 0, 16'h0, 16'h0, 0);
        set1(1, 0, 16'h0020, 16'h0, 0);
        #1;
        chk1("t1_rvalid0", rvalid0, 1'b1);
        chk1("t1_rvalid1", rvalid1, 1'b0);
        chk16("t1_rdata", rdata, 16'h1234);
        chk1("t1b_gnt1", gnt1, 1'b1);
        chk16("t1b_mem_addr", mem_addr, 16'h0020);

        // Contention without lock alternates 0,1,0,1,...
        pg = 1'b1;
        pd = 16'h5678;
        for (int k = 0; k < 6; k++) begin
            tick();
            set0(1, 0, 16'h0030, 16'h0, 0);
            set1(1, 0, 16'h0040, 16'h0, 0);
            #1;
            chk1("t2_gnt0", gnt0, (k % 2) == 0);
            chk1("t2_gnt1", gnt1, (k % 2) == 1);
            chk1("t2_rvalid0", rvalid0, !pg);
            chk1("t2_rvalid1", rvalid1, pg);
            chk16("t2_rdata", rdata, pd);
            pg = ((k % 2) == 1);
            pd = pg ? 16'h2222 : 16'h1111;
        end

        // Locked burst: 8 grants to 0, forced release, one to 1, then 0 again
        for (int k = 0; k < 12; k++) begin
            tick();
            set0(1, 0, 16'h0030, 16'h0, 1);
            set1(1, 0, 16'h0040, 16'h0, 0);
            #1;
            chk1("t3_gnt0", gnt0, k != 8);
            chk1("t3_gnt1", gnt1, k == 8);
            chk1("t3_rvalid0", rvalid0, !pg);
            chk1("t3_rvalid1", rvalid1, pg);
            chk16("t3_rdata", rdata, pd);
            pg = (k == 8);
            pd = pg ? 16'h2222 : 16'h1111;
        end

        tick();
        set0(0, 0, 16'h0, 16'h0, 0);
        set1(0, 0, 16'h0, 16'h0, 0);
        #1;
        chk1("t3_end_gnt0", gnt0, 1'b0);
        chk1("t3_end_gnt1", gnt1, 1'b0);
        chk1("t3_end_rvalid0", rvalid0, 1'b1);
        chk16("t3_end_rdata", rdata, 16'h1111);

        // Write then read-back by requester 1
        tick();
        set1(1, 1, 16'h0100, 16'hBEEF, 0);
        #1;
        chk1("t4_w_gnt1", gnt1, 1'b1);
        chk1("t4_w_mem_we", mem_we, 1'b1);
        chk16("t4_w_mem_addr", mem_addr, 16'h0100);
        chk16("t4_w_mem_wdata", mem_wdata, 16'hBEEF);
        chk1("t4_w_rvalid0", rvalid0, 1'b0);

        tick();
        set1(1, 0, 16'h0100, 16'h0, 0);
        #1;
        chk1("t4_r_gnt1", gnt1, 1'b1);
        chk1("t4_r_mem_we", mem_we, 1'b0);
        chk1("t4_r_rvalid1", rvalid1, 1'b0);

        tick();
        set1(0, 0, 16'h0, 16'h0, 0);
        #1;
        chk1("t4_rvalid1", rvalid1, 1'b1);
        chk16("t4_rdata", rdata, 16'hBEEF);
        chk1("t4_gnt1_off", gnt1, 1'b0);

        // Reset in cycle 4 of a locked burst
        for (int k = 0; k < 4; k++) begin
            tick();
            set0(1, 0, 16'h0030, 16'h0, 1);
            set1(1, 0, 16'h0040, 16'h0, 0);
            #1;
            chk1("t5_pre_gnt0", gnt0, 1'b1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk1("t5_rst_rvalid0", rvalid0, 1'b0);
        chk1("t5_rst_gnt0", gnt0, 1'b1);
        chk1("t5_rst_gnt1", gnt1, 1'b0);
        // Burst count restarted: seven more grants to 0 before release
        for (int j = 1; j < 9; j++) begin
            tick();
            #1;
            chk1("t5_gnt0", gnt0, j < 8);
            chk1("t5_gnt1", gnt1, j == 8);
            chk1("t5_rvalid0", rvalid0, 1'b1);
        end

        tick();
        set0(1'b0, 1'b1, 16'h0055, 16'h0066, 0);
        set1(1'b0, 1'b1, 16'h0077, 16'h0088, 0);
        #1;
        chk1("t5_end_rvalid1", rvalid1, 1'b1);
        chk16("t5_end_rdata", rdata, 16'h2222);
        chk1("t5_end_gnt0", gnt0, 1'b0);

        // Quiet period
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            chk1("t6_gnt0", gnt0, 1'b0);
            chk1("t6_gnt1", gnt1, 1'b0);
            chk1("t6_mem_we", mem_we, 1'b0);
            chk1("t6_rvalid0", rvalid0, 1'b0);
            chk1("t6_rvalid1", rvalid1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
